// File: rtl/pt_enc_multi.sv
// pt_enc_multi: parametrised PT2262-style tri-state remote-code encoder.
//
// Accepts a 2*N_TRITS-bit code word over a valid/ready handshake and sends it
// REPEAT times on q. Each frame is N_TRITS trit waveforms of 8 units followed
// by a 32-unit sync bit. Each unit is UNIT_CYCLES clocks long.
//
// Trit coding per 2-bit pair (MSB pair first):
//   00 = '0'    : H1 L3 H1 L3
//   01 = '1'    : H3 L1 H3 L1
//   10 = 'F'    : H1 L3 H3 L1
//   11 = open   : L8
// Sync: H1 L31.
//
// Handshake: a word transfers on any cycle where in_valid && in_ready. in_ready
// is high only in IDLE, and is driven purely by registered state. in_valid
// while busy is ignored and is not queued. The code word is captured on the
// transfer cycle, so later changes to `code` have no effect on the frame.
//
// Optional feature (macro PT_ENC_HOLD_EN): adds input `hold`. At the end of a
// frame, once REPEAT frames have been sent, hold=1 starts one more frame with
// the same latched code. hold is sampled only on the last SYNC cycle.
//
// Debug: dbg_state exposes the FSM state (0=IDLE, 1=TRIT, 2=SYNC).

module pt_enc_multi #(
  parameter int N_TRITS     = 12,
  parameter int UNIT_CYCLES = 4,
  parameter int REPEAT      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
`ifdef PT_ENC_HOLD_EN
  input  logic                   hold,
`endif
  output logic                   in_ready,
  input  logic [2*N_TRITS-1:0]   code,
  output logic                   q,
  output logic                   busy,
  output logic                   frame_done,
  output logic [1:0]             dbg_state
);

  // Counter widths: $clog2 of the count range, never narrower than 1 bit.
  localparam int TW = (N_TRITS > 1)     ? $clog2(N_TRITS)     : 1;
  localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int RW = (REPEAT > 1)      ? $clog2(REPEAT)      : 1;

  localparam logic [TW-1:0] TRIT_LAST = TW'(N_TRITS - 1);
  localparam logic [CW-1:0] CYC_LAST  = CW'(UNIT_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT - 1);
  localparam logic [4:0]    UNIT_TRIT_LAST = 5'd7;
  localparam logic [4:0]    UNIT_SYNC_LAST = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRIT = 2'd1,
    S_SYNC = 2'd2
  } state_t;

  // Current position in the frame. q shows the unit these registers point at.
  state_t               state;
  logic [2*N_TRITS-1:0] code_q;
  logic [TW-1:0]        trit_idx;
  logic [4:0]           unit_cnt;   // 0..7 in TRIT, 0..31 in SYNC
  logic [CW-1:0]        cyc_cnt;    // clocks inside the current unit
  logic [RW-1:0]        rep_cnt;    // saturates at REPEAT-1

  // Next position, computed one cycle ahead so q can be a plain register.
  state_t               n_state;
  logic [2*N_TRITS-1:0] n_code;
  logic [TW-1:0]        n_trit;
  logic [4:0]           n_unit;
  logic [CW-1:0]        n_cyc;
  logic [RW-1:0]        n_rep;
  logic                 n_q;
  logic                 n_frame_done;

  logic                 last_cyc;
  logic                 hold_cont;
  logic [2*N_TRITS-1:0] code_sh;
  logic [1:0]           trit_pair;
  logic [7:0]           trit_pat;

`ifdef PT_ENC_HOLD_EN
  assign hold_cont = hold;
`else
  assign hold_cont = 1'b0;
`endif

  assign last_cyc = (cyc_cnt == CYC_LAST);

  // Position sequencer: unit/cycle counting, trit stepping, repeat decision.
  always_comb begin
    n_state = state;
    n_code  = code_q;
    n_trit  = trit_idx;
    n_unit  = unit_cnt;
    n_cyc   = cyc_cnt;
    n_rep   = rep_cnt;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          n_state = S_TRIT;
          n_code  = code;
          n_trit  = '0;
          n_unit  = '0;
          n_cyc   = '0;
          n_rep   = '0;
        end
      end
      S_TRIT: begin
        if (last_cyc) begin
          n_cyc = '0;
          if (unit_cnt == UNIT_TRIT_LAST) begin
            n_unit = '0;
            if (trit_idx == TRIT_LAST) begin
              n_state = S_SYNC;
            end else begin
              n_trit = trit_idx + 1'b1;
            end
          end else begin
            n_unit = unit_cnt + 5'd1;
          end
        end else begin
          n_cyc = cyc_cnt + 1'b1;
        end
      end
      S_SYNC: begin
        if (last_cyc) begin
          n_cyc = '0;
          if (unit_cnt == UNIT_SYNC_LAST) begin
            n_unit = '0;
            if ((rep_cnt < REP_LAST) || hold_cont) begin
              // Next frame starts immediately, no idle gap.
              n_state = S_TRIT;
              n_trit  = '0;
              if (rep_cnt < REP_LAST) begin
                n_rep = rep_cnt + 1'b1;
              end
            end else begin
              n_state = S_IDLE;
            end
          end else begin
            n_unit = unit_cnt + 5'd1;
          end
        end else begin
          n_cyc = cyc_cnt + 1'b1;
        end
      end
      default: begin
        n_state = S_IDLE;
      end
    endcase
  end

  // Waveform lookup for the next position; trit 0 sits in the top pair.
  always_comb begin
    code_sh   = n_code << (2 * n_trit);
    trit_pair = code_sh[2*N_TRITS-1 -: 2];
    case (trit_pair)
      2'b00:   trit_pat = 8'b1000_1000;
      2'b01:   trit_pat = 8'b1110_1110;
      2'b10:   trit_pat = 8'b1000_1110;
      default: trit_pat = 8'b0000_0000;
    endcase
    case (n_state)
      S_TRIT:  n_q = trit_pat[~n_unit[2:0]];
      S_SYNC:  n_q = (n_unit == 5'd0);
      default: n_q = 1'b0;
    endcase
    n_frame_done = (n_state == S_SYNC) && (n_unit == UNIT_SYNC_LAST) &&
                   (n_cyc == CYC_LAST);
  end

  // State, counters and registered outputs; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      code_q     <= '0;
      trit_idx   <= '0;
      unit_cnt   <= '0;
      cyc_cnt    <= '0;
      rep_cnt    <= '0;
      q          <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= n_state;
      code_q     <= n_code;
      trit_idx   <= n_trit;
      unit_cnt   <= n_unit;
      cyc_cnt    <= n_cyc;
      rep_cnt    <= n_rep;
      q          <= n_q;
      frame_done <= n_frame_done;
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = ~in_ready;
  assign dbg_state = state;

endmodule

// File: tb/tb_pt_enc_multi.sv
// tb_pt_enc_multi: directed bench for pt_enc_multi.
// Three instances: a (N=2,U=1,R=1), b (N=2,U=2,R=1), c (defaults 12/4/4).
// Expected q streams are queued in exp_q and compared cycle by cycle.
// Build with +define+PT_ENC_HOLD_EN to include the hold step on instance a.
`timescale 1ns/1ps

module tb_pt_enc_multi;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // instance a
  logic       valid_a, rdy_a, q_a, busy_a, fd_a;
  logic [3:0] code_a;
  logic [1:0] st_a;
  // instance b
  logic       valid_b, rdy_b, q_b, busy_b, fd_b;
  logic [3:0] code_b;
  logic [1:0] st_b;
  // instance c
  logic        valid_c, rdy_c, q_c, busy_c, fd_c;
  logic [23:0] code_c;
  logic [1:0]  st_c;
`ifdef PT_ENC_HOLD_EN
  logic hold_a, hold_b, hold_c;
`endif

  pt_enc_multi #(.N_TRITS(2), .UNIT_CYCLES(1), .REPEAT(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(valid_a),
`ifdef PT_ENC_HOLD_EN
    .hold(hold_a),
`endif
    .in_ready(rdy_a), .code(code_a), .q(q_a), .busy(busy_a),
    .frame_done(fd_a), .dbg_state(st_a)
  );

  pt_enc_multi #(.N_TRITS(2), .UNIT_CYCLES(2), .REPEAT(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(valid_b),
`ifdef PT_ENC_HOLD_EN
    .hold(hold_b),
`endif
    .in_ready(rdy_b), .code(code_b), .q(q_b), .busy(busy_b),
    .frame_done(fd_b), .dbg_state(st_b)
  );

  pt_enc_multi dut_c (
    .clk(clk), .rst(rst), .in_valid(valid_c),
`ifdef PT_ENC_HOLD_EN
    .hold(hold_c),
`endif
    .in_ready(rdy_c), .code(code_c), .q(q_c), .busy(busy_c),
    .frame_done(fd_c), .dbg_state(st_c)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // push nbits of v, MSB first
  task automatic push_bits(input logic [31:0] v, input int nbits);
    for (int k = nbits - 1; k >= 0; k--) exp_q.push_back(v[k]);
  endtask

  // reference frame from the trit table, each unit repeated u times
  task automatic push_frame(input logic [23:0] c, input int n, input int u);
    logic [7:0] pat;
    logic [1:0] pr;
    for (int t = 0; t < n; t++) begin
      pr = c[2*(n-1-t) +: 2];
      case (pr)
        2'b00:   pat = 8'b1000_1000;
        2'b01:   pat = 8'b1110_1110;
        2'b10:   pat = 8'b1000_1110;
        default: pat = 8'b0000_0000;
      endcase
      for (int b = 7; b >= 0; b--)
        for (int r = 0; r < u; r++) exp_q.push_back(pat[b]);
    end
    for (int r = 0; r < u; r++) exp_q.push_back(1'b1);
    for (int r = 0; r < 31*u; r++) exp_q.push_back(1'b0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic get_out(input int sel, output logic qq, output logic fd,
                         output logic rdy, output logic bsy, output logic [1:0] st);
    case (sel)
      0:       begin qq = q_a; fd = fd_a; rdy = rdy_a; bsy = busy_a; st = st_a; end
      1:       begin qq = q_b; fd = fd_b; rdy = rdy_b; bsy = busy_b; st = st_b; end
      default: begin qq = q_c; fd = fd_c; rdy = rdy_c; bsy = busy_c; st = st_c; end
    endcase
  endtask

  // check the idle output set of one instance
  task automatic chk_idle(input int sel, input string tag);
    logic qq, fd, rdy, bsy;
    logic [1:0] st;
    get_out(sel, qq, fd, rdy, bsy, st);
    chk($sformatf("%s q", tag), 32'(qq), 32'd0);
    chk($sformatf("%s in_ready", tag), 32'(rdy), 32'd1);
    chk($sformatf("%s busy", tag), 32'(bsy), 32'd0);
    chk($sformatf("%s frame_done", tag), 32'(fd), 32'd0);
    chk($sformatf("%s state", tag), 32'(st), 32'd0);
  endtask

  // cycle T: present word; returns in cycle T+1 with the code changed
  task automatic send(input int sel, input logic [23:0] c, input string tag);
    logic qq, fd, rdy, bsy;
    logic [1:0] st;
    get_out(sel, qq, fd, rdy, bsy, st);
    chk($sformatf("%s ready at T", tag), 32'(rdy), 32'd1);
    case (sel)
      0:       begin valid_a = 1'b1; code_a = c[3:0]; end
      1:       begin valid_b = 1'b1; code_b = c[3:0]; end
      default: begin valid_c = 1'b1; code_c = c; end
    endcase
    tick();
    case (sel)
      0:       begin valid_a = 1'b0; code_a = ~c[3:0]; end
      1:       begin valid_b = 1'b0; code_b = ~c[3:0]; end
      default: begin valid_c = 1'b0; code_c = ~c; end
    endcase
  endtask

  // compare n_cyc cycles starting at T+1 against exp_q
  task automatic run_check(input int sel, input int n_cyc, input int flen,
                           input int pulse_at, input int hold_until, input string tag);
    logic qq, fd, rdy, bsy;
    logic [1:0] st;
    logic [0:0] eb;
    for (int i = 0; i < n_cyc; i++) begin
      if (sel == 2 && pulse_at >= 0) begin
        valid_c = (i == pulse_at);
        code_c  = 24'h000000;
      end
`ifdef PT_ENC_HOLD_EN
      if (sel == 0) hold_a = (i < hold_until);
`endif
      get_out(sel, qq, fd, rdy, bsy, st);
      eb = exp_q.pop_front();
      chk($sformatf("%s q[%0d]", tag, i), 32'(qq), 32'(eb));
      chk($sformatf("%s frame_done[%0d]", tag, i), 32'(fd), 32'((i % flen) == (flen - 1)));
      chk($sformatf("%s busy[%0d]", tag, i), 32'(bsy), 32'd1);
      if (i == 0) chk($sformatf("%s state@T+1", tag), 32'(st), 32'd1);
      tick();
    end
    valid_c = 1'b0;
`ifdef PT_ENC_HOLD_EN
    hold_a = 1'b0;
`endif
    if (hold_until < 0) $display("unused hold_until");
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    code_a = '0; code_b = '0; code_c = '0;
`ifdef PT_ENC_HOLD_EN
    hold_a = 1'b0; hold_b = 1'b0; hold_c = 1'b0;
`endif

    // reset held 3 cycles, then released
    for (int r = 0; r < 3; r++) begin
      tick();
      for (int s = 0; s < 3; s++) chk_idle(s, $sformatf("reset%0d dut%0d", r, s));
    end
    rst = 1'b0;
    tick();
    for (int s = 0; s < 3; s++) chk_idle(s, $sformatf("post_reset dut%0d", s));

    // N=2 U=1 R=1, code 0001: 10001000 11101110, then 1 and 31 zeros
    exp_q.delete();
    push_bits(32'b1000_1000_1110_1110, 16);
    push_bits(32'h8000_0000, 32);
    send(0, 24'h000001, "small");
    run_check(0, 48, 48, -1, 0, "small");
    chk_idle(0, "small T+49");

    // N=2 U=2 R=1, code 1011: 'F' then open, each unit doubled, 96 cycles
    exp_q.delete();
    push_bits(32'b1100_0000_1111_1100_0000_0000_0000_0000, 32);
    push_bits(32'hC000_0000, 32);
    push_bits(32'h0000_0000, 32);
    send(1, 24'h00000B, "f_open");
    run_check(1, 96, 96, -1, 0, "f_open");
    chk_idle(1, "f_open T+97");

    // defaults, all '1' trits, 4 frames back to back; stray word at T+700
    exp_q.delete();
    for (int f = 0; f < 4; f++) push_frame(24'h555555, 12, 4);
    send(2, 24'h555555, "repeat");
    run_check(2, 2048, 512, 699, 0, "repeat");
    for (int k = 0; k < 4; k++) begin
      chk_idle(2, $sformatf("repeat idle+%0d", k));
      tick();
    end

    // defaults, reset at T+200 aborts the frame
    exp_q.delete();
    push_frame(24'h1B1B1B, 12, 4);
    send(2, 24'h1B1B1B, "midrst");
    run_check(2, 199, 512, -1, 0, "midrst");
    rst = 1'b1;          // cycle T+200
    tick();
    chk_idle(2, "midrst T+201");
    rst = 1'b0;
    tick();
    chk_idle(2, "midrst release");

    // clean frame after the abort, starting from trit 0
    exp_q.delete();
    push_frame(24'hE4E4E4, 12, 4);
    send(2, 24'hE4E4E4, "restart");
    run_check(2, 512, 512, -1, 0, "restart");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk_idle(2, "restart cleared");

`ifdef PT_ENC_HOLD_EN
    // R=1 with hold=1 across 3 frame ends, 0 on the 4th: exactly 4 frames
    exp_q.delete();
    for (int f = 0; f < 4; f++) push_frame(24'h000009, 2, 1);
    hold_a = 1'b1;
    send(0, 24'h000009, "hold");
    run_check(0, 192, 48, -1, 144, "hold");
    chk_idle(0, "hold end");
    tick();
    chk_idle(0, "hold end+1");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pt_enc_multi.md
Name: pt_enc_multi

Overview:
- Parametrised PT2262-style tri-state remote-code encoder; successor to the fixed 12-trit, single-frame encoder.
- Accepts an N-trit code word over a valid/ready handshake and serialises it as trit waveforms followed by a sync bit.
- Repeats the frame a configurable number of times; drives the RF/OOK transmitter pin `q`.
- Sits between the UART command decoder and the transmitter output.

Parameters:
- N_TRITS, 12: trits per frame; the code word is 2*N_TRITS bits wide.
- UNIT_CYCLES, 4: clk cycles per timing unit α; must be ≥1.
- REPEAT, 4: frames sent per accepted word; must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  code word valid
- in_ready  out  1  block idle, can accept a word
- code  in  2*N_TRITS  trits, MSB pair first; per pair: 00=0, 01=1, 10=F, 11=open
- q  out  1  serial encoded output
- busy  out  1  transmission in progress (equals ~in_ready)
- frame_done  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Reset values: q=0, busy=0, in_ready=1, frame_done=0. All counters are cleared and the state is IDLE.
- Reset applied mid-frame aborts the frame; q is 0 from the next cycle.
- States: IDLE, TRIT, SYNC.
- IDLE:
  - in_ready=1, q=0.
  - On in_valid&&in_ready at cycle T: latch code, set repeat counter to 0, trit index to 0, go to TRIT.
  - q carries the first unit of trit 0 from cycle T+1.
  - Changes to code after cycle T are ignored.
- Trit waveform: 8 units, listed as high/low unit runs.
  - 0: H1 L3 H1 L3
  - 1: H3 L1 H3 L1
  - F: H1 L3 H3 L1
  - open (11): L8
- Sync waveform: H1 L31 (32 units).
- Every unit lasts exactly UNIT_CYCLES cycles; q is registered.
- Trits are sent from code[2N-1:2N-2] down to code[1:0]. After the last trit the state goes to SYNC.
- Frame length is (8*N_TRITS+32)*UNIT_CYCLES cycles. With defaults this is 512 cycles.
- On the last cycle of SYNC:
  - frame_done=1.
  - If the repeat counter is below REPEAT-1: increment it, reset the trit index, go to TRIT. Frames are back-to-back with no gap cycle.
  - Otherwise go to IDLE. in_ready rises on the next cycle.
- in_valid while busy is ignored and not queued.
- Counter widths are sized with $clog2 of their maximum, with a minimum width of 1. No counter wraps inside a frame.
- A unit counter of 0..31 serves both trit (0..7) and sync (0..31) phases.

Optional Feature:
- Macro: PT_ENC_HOLD_EN
- When defined:
  - Adds input port `hold` (1 bit), listed after in_valid.
  - At the end of the final repeat, if hold=1, the block starts another frame with the same latched code instead of going IDLE.
  - Transmission stops at the first frame end where hold=0 and at least REPEAT frames have been sent.
  - hold is sampled only on the last SYNC cycle.
- When undefined: no hold port; exactly REPEAT frames are sent per word.

Test Plan:
- Reset check: assert rst for 3 cycles with defaults → q=0, in_ready=1, busy=0, frame_done=0 throughout and after release.
- Small-parameter waveform: N_TRITS=2, UNIT_CYCLES=1, REPEAT=1, code=4'b0001 at T → q from T+1 is 10001000 11101110 then 1 followed by 31 zeros. frame_done high at T+48, in_ready=1 at T+49.
- F and open trits: N_TRITS=2, UNIT_CYCLES=2, code=4'b1011 → each unit of 10001110 00000000 is doubled, so q = 1100000011111100 followed by 16 zeros, then the sync bit. Frame is 96 cycles.
- Repeat and busy: defaults, code=24'h555555 (all 1), REPEAT=4 → frame_done pulses at T+512, +1024, +1536, +2048. q has no gap between frames. Pulsing in_valid at T+700 with a different code changes nothing.
- Reset mid-frame: defaults, assert rst at T+200 → q=0 at T+201, in_ready=1 after release. A new word accepted afterwards produces a clean frame starting from trit 0.
- With PT_ENC_HOLD_EN: REPEAT=1, hold=1 for 3 frames, then 0 → exactly 4 frames, 4 frame_done pulses, then IDLE.
